// File: rtl/pic_fetch_sequencer_if.sv
// Program-memory fetch bus between the PIC16F84 fetch sequencer
// and the instruction ROM.
interface pic_fetch_sequencer_if #(
  parameter int PM_AW = 10
);
  logic [PM_AW-1:0] PM_ADDR;
  logic [13:0]      PM_DATA;

  modport master (
    output PM_ADDR,
    input  PM_DATA
  );

  modport slave (
    input  PM_ADDR,
    output PM_DATA
  );
endinterface

// File: rtl/pic_fetch_sequencer.sv
// PIC16F84 fetch/sequencing front end: Q1-Q4 phase, PC, return stack
// and the two-stage fetch/execute pipeline with redirect flush.
module pic_fetch_sequencer #(
  parameter int PC_W      = 13,
  parameter int PM_AW     = 10,
  parameter int STK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pic_fetch_sequencer_if.master pm,
  input  logic [4:0]            PCLATH,
  input  logic                  SKIP,
  input  logic                  PC_LOAD,
  input  logic [7:0]            PC_LOAD_VAL,
  output logic [13:0]           OP_CODE,
  output logic                  OP_VALID,
  output logic [1:0]            Q_STATE,
  output logic [PC_W-1:0]       PC_OUT,
  output logic                  STK_ERR
);

  localparam int SP_W = $clog2(STK_DEPTH);
  localparam int DW   = $clog2(STK_DEPTH + 1);
  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
  localparam logic [DW-1:0]   D_ONE  = DW'(1);
  localparam logic [DW-1:0]   D_FULL = DW'(STK_DEPTH);
  localparam logic [SP_W-1:0] S_ONE  = SP_W'(1);

  logic [1:0]      q_q, q_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [13:0]     ir_q, ir_d;
  logic            vld_q, vld_d;
  logic [SP_W-1:0] sp_q, sp_d, sp_m1;
  logic [DW-1:0]   dep_q, dep_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] stk_q [STK_DEPTH];

  logic            take, push, pop, redir;
  logic            is_goto, is_call, is_ret;
  logic            sel_ld, sel_go, sel_call, sel_ret, sel_skp;
  logic [PC_W-1:0] tgt;

  assign sp_m1   = sp_q - S_ONE;
  assign tgt     = {PCLATH[4:3], ir_q[10:0]};
  assign is_goto = ir_q[13:11] == 3'b101;
  assign is_call = ir_q[13:11] == 3'b100;
  assign is_ret  = (ir_q == 14'h0008) || (ir_q == 14'h0009)
                || (ir_q[13:10] == 4'b1101);

  // Redirects only act on a real instruction at the Q4 edge; the
  // selects are masked so exactly one (or none) is ever active.
  assign take     = (q_q == 2'd3) && vld_q;
  assign sel_ld   = take && PC_LOAD;
  assign sel_go   = take && !PC_LOAD && is_goto;
  assign sel_call = take && !PC_LOAD && is_call;
  assign sel_ret  = take && !PC_LOAD && is_ret;
  assign sel_skp  = take && !PC_LOAD && !is_goto
                 && !is_call && !is_ret && SKIP;

  always_comb begin
    q_d   = q_q + 2'd1;
    pc_d  = pc_q;
    ir_d  = ir_q;
    vld_d = vld_q;
    sp_d  = sp_q;
    dep_d = dep_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    redir = 1'b1;
    if (q_q == 2'd3) begin
      ir_d  = pm.PM_DATA;
      vld_d = 1'b1;
      pc_d  = pc_q + PC_ONE;
    end
    unique case (1'b1)
      sel_ld:   pc_d = {PCLATH, PC_LOAD_VAL};
      sel_go:   pc_d = tgt;
      sel_call: begin
        pc_d = tgt;
        push = 1'b1;
      end
      sel_ret: begin
        pc_d = stk_q[sp_m1];
        pop  = 1'b1;
      end
      sel_skp:  pc_d = pc_q + PC_ONE;
      default:  redir = 1'b0;
    endcase
    if (redir) begin
      ir_d  = '0;
      vld_d = 1'b0;
    end
    if (push) begin
      sp_d = sp_q + S_ONE;
      if (dep_q == D_FULL) err_d = 1'b1;
      else                 dep_d = dep_q + D_ONE;
    end
    if (pop) begin
      sp_d = sp_m1;
      if (dep_q == '0) err_d = 1'b1;
      else             dep_d = dep_q - D_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q   <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      vld_q <= 1'b0;
      sp_q  <= '0;
      dep_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      q_q   <= q_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      vld_q <= vld_d;
      sp_q  <= sp_d;
      dep_q <= dep_d;
      err_q <= err_d;
      if (push) stk_q[sp_q] <= pc_q;
    end
  end

  assign pm.PM_ADDR = pc_q[PM_AW-1:0];
  assign OP_CODE    = ir_q;
  assign OP_VALID   = vld_q;
  assign Q_STATE    = q_q;
  assign PC_OUT     = pc_q;
  assign STK_ERR    = err_q;

endmodule

// File: tb/tb_pic_fetch_sequencer.sv
// Directed checks of the fetch sequencer against a small program ROM
// held in the bench.
module tb_pic_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  PCLATH = '0;
  logic        SKIP = 1'b0;
  logic        PC_LOAD = 1'b0;
  logic [7:0]  PC_LOAD_VAL = '0;
  logic [13:0] OP_CODE;
  logic        OP_VALID;
  logic [1:0]  Q_STATE;
  logic [12:0] PC_OUT;
  logic        STK_ERR;

  logic [13:0] mem [1024];
  int n_vec = 0;
  int n_err = 0;

  pic_fetch_sequencer_if pm ();
  assign pm.PM_DATA = mem[pm.PM_ADDR];

  pic_fetch_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pm         (pm.master),
    .PCLATH     (PCLATH),
    .SKIP       (SKIP),
    .PC_LOAD    (PC_LOAD),
    .PC_LOAD_VAL(PC_LOAD_VAL),
    .OP_CODE    (OP_CODE),
    .OP_VALID   (OP_VALID),
    .Q_STATE    (Q_STATE),
    .PC_OUT     (PC_OUT),
    .STK_ERR    (STK_ERR)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 14'h0000;
  endtask

  task automatic do_reset();
    SKIP = 1'b0;
    PC_LOAD = 1'b0;
    PC_LOAD_VAL = '0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic nxt();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic nxt_n(input int n);
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    // Sequential fetch and Q phase
    clr_mem();
    mem[0] = 14'h3055; mem[1] = 14'h0080; mem[2] = 14'h3801;
    PCLATH = 5'h00;
    do_reset();
    chk("rst_op", OP_CODE, 14'h0000);
    chk("rst_vld", OP_VALID, 1'b0);
    chk("rst_addr", pm.PM_ADDR, 10'h000);
    chk("rst_err", STK_ERR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("qphase", Q_STATE, i[1:0]);
      @(posedge clk);
      #1;
    end
    chk("c1_op", OP_CODE, 14'h3055);
    chk("c1_vld", OP_VALID, 1'b1);
    nxt();
    chk("c2_op", OP_CODE, 14'h0080);
    nxt();
    chk("c3_op", OP_CODE, 14'h3801);
    chk("c3_pc", PC_OUT, 13'h0003);
    nxt();
    chk("c4_pc", PC_OUT, 13'h0004);

    // GOTO with PCLATH page bits
    clr_mem();
    mem[2] = 14'h2810; mem[10'h010] = 14'h3A5A;
    PCLATH = 5'h18;
    do_reset();
    nxt_n(3);
    chk("goto_op", OP_CODE, 14'h2810);
    nxt();
    chk("goto_vld", OP_VALID, 1'b0);
    chk("goto_addr", pm.PM_ADDR, 10'h010);
    chk("goto_pc", PC_OUT, 13'h1810);
    nxt();
    chk("goto_tgt", OP_CODE, 14'h3A5A);
    chk("goto_tvld", OP_VALID, 1'b1);

    // GOTO to top of memory, PC wraps
    clr_mem();
    mem[0] = 14'h2FFF; mem[10'h3FF] = 14'h3111;
    PCLATH = 5'h18;
    do_reset();
    nxt_n(2);
    chk("wrap_pc0", PC_OUT, 13'h1FFF);
    chk("wrap_addr", pm.PM_ADDR, 10'h3FF);
    nxt();
    chk("wrap_op", OP_CODE, 14'h3111);
    chk("wrap_pc1", PC_OUT, 13'h0000);

    // CALL / RETURN round trip
    clr_mem();
    mem[5] = 14'h2020; mem[10'h020] = 14'h0008; mem[6] = 14'h3F06;
    PCLATH = 5'h00;
    do_reset();
    nxt_n(6);
    chk("call_op", OP_CODE, 14'h2020);
    nxt();
    chk("call_vld", OP_VALID, 1'b0);
    chk("call_pc", PC_OUT, 13'h0020);
    nxt();
    chk("ret_op", OP_CODE, 14'h0008);
    nxt();
    chk("ret_vld", OP_VALID, 1'b0);
    chk("ret_pc", PC_OUT, 13'h0006);
    nxt();
    chk("ret_back", OP_CODE, 14'h3F06);
    chk("ret_err", STK_ERR, 1'b0);

    // SKIP squashes the next fetch; ignored on the flush cycle
    clr_mem();
    mem[3] = 14'h1C03; mem[4] = 14'h3004; mem[5] = 14'h3005;
    do_reset();
    nxt_n(4);
    chk("skp_op", OP_CODE, 14'h1C03);
    SKIP = 1'b1;
    nxt();
    chk("skp_op0", OP_CODE, 14'h0000);
    chk("skp_vld", OP_VALID, 1'b0);
    chk("skp_pc", PC_OUT, 13'h0005);
    nxt();
    SKIP = 1'b0;
    chk("skp_nxt", OP_CODE, 14'h3005);
    chk("skp_pc2", PC_OUT, 13'h0006);

    // PC_LOAD outranks GOTO; ignored when OP_VALID=0
    clr_mem();
    mem[1] = 14'h2810; mem[10'h240] = 14'h3240;
    PCLATH = 5'h02;
    do_reset();
    nxt_n(2);
    chk("ld_op", OP_CODE, 14'h2810);
    PC_LOAD = 1'b1;
    PC_LOAD_VAL = 8'h40;
    nxt();
    chk("ld_pc", PC_OUT, 13'h0240);
    chk("ld_addr", pm.PM_ADDR, 10'h240);
    chk("ld_vld", OP_VALID, 1'b0);
    nxt();
    PC_LOAD = 1'b0;
    chk("ld_tgt", OP_CODE, 14'h3240);
    chk("ld_pc2", PC_OUT, 13'h0241);

    // Nine nested CALLs overflow the circular stack
    clr_mem();
    for (int n = 0; n < 9; n++) begin
      mem[n * 16]     = 14'h2000 | 14'((n + 1) * 16);
      mem[n * 16 + 1] = 14'h0008;
    end
    mem[10'h090] = 14'h0008;
    PCLATH = 5'h00;
    do_reset();
    nxt();
    for (int n = 0; n < 9; n++) begin
      chk("ovf_call", OP_CODE, 14'h2000 | 14'((n + 1) * 16));
      nxt();
      chk("ovf_pc", PC_OUT, 13'((n + 1) * 16));
      chk("ovf_err", STK_ERR, (n == 8));
      nxt();
    end
    chk("ovf_ret", OP_CODE, 14'h0008);
    for (int k = 1; k <= 9; k++) begin
      nxt();
      chk("pop_pc", PC_OUT,
          (k == 9) ? 13'h0081 : 13'(16 * (9 - k) + 1));
      nxt();
    end
    chk("pop_err", STK_ERR, 1'b1);

    // Reset at Q2 while executing a CALL target
    clr_mem();
    mem[5] = 14'h2020; mem[10'h020] = 14'h0008; mem[6] = 14'h3F06;
    do_reset();
    nxt_n(8);
    chk("mr_op", OP_CODE, 14'h0008);
    @(posedge clk);
    #1;
    chk("mr_q1", Q_STATE, 2'd1);
    rst_n = 1'b0;
    mem[0] = 14'h0008;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mr_q", Q_STATE, 2'd0);
    chk("mr_pc", PC_OUT, 13'h0000);
    chk("mr_ir", OP_CODE, 14'h0000);
    chk("mr_vld", OP_VALID, 1'b0);
    chk("mr_err", STK_ERR, 1'b0);
    nxt();
    chk("mr_ret", OP_CODE, 14'h0008);
    nxt();
    chk("mr_poppc", PC_OUT, 13'h0000);
    chk("mr_uflow", STK_ERR, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
